// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the core's data-memory port: a word-addressed RAM plus a
//   small MMIO window. The window holds a free-running cycle counter, a
//   committed-store counter, a GPIO output register and a TOHOST halt mailbox.
//   Loads are combinational (zero latency). Stores commit on the posedge that
//   ends the request cycle.
//
// Ports
//   CLK           in   1   clock, all state updates on posedge
//   RST           in   1   synchronous reset, active-high
//   DataMemAddr   in   32  byte address
//   DataMemRead   in   1   load request
//   DataMemWrite  in   1   store request
//   DataMemWData  in   32  store data
//   DataMemRData  out  32  load data, combinational; 0 when no load is requested
//   GpioOut       out  32  GPIO_OUT register
//   Halt          out  1   sticky, set by the first TOHOST store
//   HaltCode      out  32  data of the first TOHOST store
//   ErrFlags      out  2   sticky {RangeErr, MisalignErr}
module data_mem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] DataMemAddr,
   input  logic        DataMemRead,
   input  logic        DataMemWrite,
   input  logic [31:0] DataMemWData,
   output logic [31:0] DataMemRData,
   output logic [31:0] GpioOut,
   output logic        Halt,
   output logic [31:0] HaltCode,
   output logic [1:0]  ErrFlags
);

   localparam logic [5:0] OFS_CYCLE  = 6'd0;
   localparam logic [5:0] OFS_SCNT   = 6'd1;
   localparam logic [5:0] OFS_GPIO   = 6'd2;
   localparam logic [5:0] OFS_TOHOST = 6'd3;

   logic [31:0] r_mem [DEPTH];

   logic [31:0] r_cycle;
   logic [31:0] r_store_cnt;
   logic [31:0] r_gpio;
   logic [31:0] r_halt_code;
   logic        r_halt;
   logic        r_range_err;
   logic        r_misalign_err;

   logic              w_req;
   logic              w_misalign;
   logic              w_mmio;
   logic              w_ram;
   logic              w_range;
   logic [5:0]        w_ofs;
   logic [ADDR_W-1:0] w_idx;
   logic              w_ram_we;
   logic              w_gpio_we;
   logic              w_tohost_we;
   logic [31:0]       w_rdata;

   // Decode in priority order: misaligned, MMIO window, RAM, out of range.
   assign w_req      = DataMemRead | DataMemWrite;
   assign w_misalign = w_req && (DataMemAddr[1:0] != 2'b00);
   assign w_mmio     = w_req && !w_misalign
                       && (DataMemAddr[31:28] == MMIO_BASE[31:28]);
   assign w_ram      = w_req && !w_misalign && !w_mmio
                       && (DataMemAddr[31:ADDR_W+2] == '0);
   assign w_range    = w_req && !w_misalign && !w_mmio && !w_ram;

   assign w_ofs = DataMemAddr[7:2];
   assign w_idx = DataMemAddr[ADDR_W+1:2];

   // A store in a reset cycle must not reach the RAM, since RAM is not reset.
   assign w_ram_we    = DataMemWrite && w_ram && !r_halt && !RST;
   assign w_gpio_we   = DataMemWrite && w_mmio && (w_ofs == OFS_GPIO) && !r_halt;
   assign w_tohost_we = DataMemWrite && w_mmio && (w_ofs == OFS_TOHOST) && !r_halt;

   // Load path reads current state, so a simultaneous store returns the old value.
   always_comb begin
      w_rdata = '0;
      if (DataMemRead) begin
         if (w_ram) begin
            w_rdata = r_mem[w_idx];
         end else if (w_mmio) begin
            case (w_ofs)
               OFS_CYCLE: w_rdata = r_cycle;
               OFS_SCNT:  w_rdata = r_store_cnt;
               OFS_GPIO:  w_rdata = r_gpio;
               default:   w_rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_ram_we) begin
         r_mem[w_idx] <= DataMemWData;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cycle        <= '0;
         r_store_cnt    <= '0;
         r_gpio         <= '0;
         r_halt         <= 1'b0;
         r_halt_code    <= '0;
         r_range_err    <= 1'b0;
         r_misalign_err <= 1'b0;
      end else begin
         if (!r_halt) begin
            r_cycle <= r_cycle + 32'd1;
         end
         if (w_ram_we && (r_store_cnt != 32'hFFFF_FFFF)) begin
            r_store_cnt <= r_store_cnt + 32'd1;
         end
         if (w_gpio_we) begin
            r_gpio <= DataMemWData;
         end
         if (w_tohost_we) begin
            r_halt      <= 1'b1;
            r_halt_code <= DataMemWData;
         end
         if (w_misalign) begin
            r_misalign_err <= 1'b1;
         end
         if (w_range) begin
            r_range_err <= 1'b1;
         end
      end
   end

   assign DataMemRData = w_rdata;
   assign GpioOut      = r_gpio;
   assign Halt         = r_halt;
   assign HaltCode     = r_halt_code;
   assign ErrFlags     = {r_range_err, r_misalign_err};

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. A behavioural model tracks memory
//   contents and MMIO state with plain arithmetic on byte addresses; a compare
//   process checks every output against it on each negedge, and the directed
//   sequence adds hand-computed literal expectations.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;

   logic        CLK;
   logic        RST;
   logic [31:0] DataMemAddr;
   logic        DataMemRead;
   logic        DataMemWrite;
   logic [31:0] DataMemWData;
   logic [31:0] DataMemRData;
   logic [31:0] GpioOut;
   logic        Halt;
   logic [31:0] HaltCode;
   logic [1:0]  ErrFlags;

   data_mem_responder #(
      .DEPTH    (DEPTH),
      .ADDR_W   (10),
      .MMIO_BASE(32'hF000_0000)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .DataMemAddr (DataMemAddr),
      .DataMemRead (DataMemRead),
      .DataMemWrite(DataMemWrite),
      .DataMemWData(DataMemWData),
      .DataMemRData(DataMemRData),
      .GpioOut     (GpioOut),
      .Halt        (Halt),
      .HaltCode    (HaltCode),
      .ErrFlags    (ErrFlags)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, keyed by word index of written locations only.
   logic [31:0] m_mem [int];
   logic [31:0] m_cycle, m_scnt, m_gpio, m_code;
   bit          m_halt, m_rerr, m_merr;
   bit          m_live = 0;

   always @(posedge CLK) begin
      logic [31:0] a;
      bit          was_halted;
      a          = DataMemAddr;
      was_halted = m_halt;
      if (RST) begin
         m_cycle = 0; m_scnt = 0; m_gpio = 0; m_code = 0;
         m_halt  = 0; m_rerr = 0; m_merr = 0;
         m_live  = 1;
      end else if (m_live) begin
         if (DataMemRead || DataMemWrite) begin
            if (a % 4 != 0) begin
               m_merr = 1;
            end else if (a >= 32'hF000_0000) begin
               if (DataMemWrite && !was_halted) begin
                  if ((a % 256) / 4 == 2) m_gpio = DataMemWData;
                  if ((a % 256) / 4 == 3) begin
                     m_halt = 1;
                     m_code = DataMemWData;
                  end
               end
            end else if (a < DEPTH * 4) begin
               if (DataMemWrite && !was_halted) begin
                  m_mem[int'(a / 4)] = DataMemWData;
                  if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
               end
            end else begin
               m_rerr = 1;
            end
         end
         if (!was_halted) m_cycle = m_cycle + 1;
      end
   end

   task automatic model_rdata(output bit known, output logic [31:0] v);
      logic [31:0] a;
      a     = DataMemAddr;
      known = 1;
      v     = 0;
      if (!DataMemRead || (a % 4 != 0)) begin
         v = 0;
      end else if (a >= 32'hF000_0000) begin
         case ((a % 256) / 4)
            0:       v = m_cycle;
            1:       v = m_scnt;
            2:       v = m_gpio;
            default: v = 0;
         endcase
      end else if (a < DEPTH * 4) begin
         if (m_mem.exists(int'(a / 4))) v = m_mem[int'(a / 4)];
         else known = 0;
      end
   endtask

   always @(negedge CLK) begin
      bit          known;
      logic [31:0] v;
      if (m_live && !RST) begin
         chk("m_gpio", GpioOut, m_gpio);
         chk("m_halt", {31'b0, Halt}, {31'b0, m_halt});
         chk("m_haltcode", HaltCode, m_code);
         chk("m_errflags", {30'b0, ErrFlags}, {30'b0, m_rerr, m_merr});
         model_rdata(known, v);
         if (known) chk("m_rdata", DataMemRData, v);
      end
   end

   task automatic req(input bit rst, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
      @(posedge CLK);
      #1;
      RST          = rst;
      DataMemRead  = rd;
      DataMemWrite = wr;
      DataMemAddr  = a;
      DataMemWData = d;
      #2;
   endtask

   initial begin
      RST = 1'b1; DataMemRead = 0; DataMemWrite = 0; DataMemAddr = 0; DataMemWData = 0;
      req(1, 0, 0, 32'h0, 32'h0);
      req(1, 0, 0, 32'h0, 32'h0);
      chk("rst_gpio", GpioOut, 32'h0);
      chk("rst_halt", {31'b0, Halt}, 32'h0);
      chk("rst_haltcode", HaltCode, 32'h0);
      chk("rst_err", {30'b0, ErrFlags}, 32'h0);

      // Ten cycles after release, CYCLE reads 10.
      for (int i = 0; i < 10; i++) req(0, 0, 0, 32'h0, 32'h0);
      req(0, 1, 0, 32'hF000_0000, 32'h0);
      chk("t5_cycle10", DataMemRData, 32'd10);

      // T1
      req(0, 0, 1, 32'h40, 32'hDEAD_BEEF);
      req(0, 1, 0, 32'h40, 32'h0);
      chk("t1_load", DataMemRData, 32'hDEAD_BEEF);
      req(0, 1, 0, 32'hF000_0004, 32'h0);
      chk("t1_storecnt", DataMemRData, 32'd1);

      // T2
      req(0, 1, 0, 32'h41, 32'h0);
      chk("t2_misload", DataMemRData, 32'h0);
      req(0, 0, 1, 32'h42, 32'h1234_5678);
      req(0, 1, 0, 32'h40, 32'h0);
      chk("t2_ram_kept", DataMemRData, 32'hDEAD_BEEF);
      chk("t2_err", {30'b0, ErrFlags}, 32'h1);
      req(0, 1, 0, 32'hF000_0004, 32'h0);
      chk("t2_storecnt", DataMemRData, 32'd1);

      // T3
      req(0, 0, 1, 32'h1000, 32'h5);
      req(0, 1, 0, 32'h1000, 32'h0);
      chk("t3_range_load", DataMemRData, 32'h0);
      chk("t3_err", {30'b0, ErrFlags}, 32'h3);

      // T4
      req(0, 0, 1, 32'hF000_0008, 32'h5A);
      req(0, 1, 0, 32'hF000_0008, 32'h0);
      chk("t4_gpio_out", GpioOut, 32'h5A);
      chk("t4_gpio_load", DataMemRData, 32'h5A);
      req(0, 0, 1, 32'hF000_0000, 32'h123);
      req(0, 1, 0, 32'hF000_000C, 32'h0);
      chk("t4_tohost_reads0", DataMemRData, 32'h0);

      // Simultaneous read and write returns the pre-store value.
      req(0, 0, 1, 32'h44, 32'h111);
      req(0, 1, 1, 32'h44, 32'h222);
      chk("rw_old", DataMemRData, 32'h111);
      req(0, 1, 0, 32'h44, 32'h0);
      chk("rw_new", DataMemRData, 32'h222);
      req(0, 0, 1, 32'h80, 32'h11);
      req(0, 1, 0, 32'hF000_0004, 32'h0);
      chk("storecnt4", DataMemRData, 32'd4);

      // T5 halt part
      req(0, 0, 1, 32'hF000_000C, 32'h7);
      req(0, 0, 0, 32'h0, 32'h0);
      chk("t5_halt", {31'b0, Halt}, 32'h1);
      chk("t5_code", HaltCode, 32'h7);
      req(0, 0, 1, 32'h40, 32'hBAD);
      req(0, 1, 0, 32'h40, 32'h0);
      chk("t5_ram_dropped", DataMemRData, 32'hDEAD_BEEF);
      req(0, 0, 1, 32'hF000_000C, 32'h9);
      req(0, 0, 1, 32'hF000_0008, 32'h77);
      req(0, 1, 0, 32'hF000_0004, 32'h0);
      chk("t5_code_kept", HaltCode, 32'h7);
      chk("t5_gpio_kept", GpioOut, 32'h5A);
      chk("t5_storecnt_kept", DataMemRData, 32'd4);
      for (int i = 0; i < 3; i++) req(0, 1, 0, 32'hF000_0000, 32'h0);

      // T6
      req(1, 0, 1, 32'h80, 32'hABC);
      req(0, 1, 0, 32'hF000_0000, 32'h0);
      chk("t6_cycle0", DataMemRData, 32'h0);
      chk("t6_halt", {31'b0, Halt}, 32'h0);
      chk("t6_err", {30'b0, ErrFlags}, 32'h0);
      chk("t6_gpio", GpioOut, 32'h0);
      chk("t6_code", HaltCode, 32'h0);
      req(0, 1, 0, 32'h80, 32'h0);
      chk("t6_ram_kept", DataMemRData, 32'h11);
      req(0, 1, 0, 32'hF000_0004, 32'h0);
      chk("t6_storecnt", DataMemRData, 32'h0);

      req(0, 0, 0, 32'h0, 32'h0);
      @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
